// File: rtl/fpu_decode_issue.sv
`default_nettype none
// ============================================================================
// Module   : fpu_decode_issue
// Desc     : RV32F decode and issue stage sitting behind the FPU fetch FSM.
//            Decodes the presented instruction into a one-hot sfpu opcode
//            vector plus register / rounding-mode fields, issues it to the
//            execute datapath with valid/ready, and tracks fdiv/fsqrt as
//            multi-cycle ops so the fetch FSM holds while they are in flight.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_decode_issue #(
    parameter int DIV_CYCLES = 16,
    parameter int OPW        = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr_in,
    input  logic            exec_ready,
    output logic [OPW-1:0]  sfpu_op,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rs3,
    output logic [4:0]      rd,
    output logic [2:0]      rm,
    output logic            issue_valid,
    output logic            multi_cycle,
    output logic            activation,
    output logic            done,
    output logic            illegal
);

    // Counter only has to hold DIV_CYCLES-1.
    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    // sfpu opcode vector bit positions.
    localparam int c_FADD    = 0;
    localparam int c_FSUB    = 1;
    localparam int c_FMUL    = 2;
    localparam int c_FDIV    = 3;
    localparam int c_FSQRT   = 4;
    localparam int c_FMIN    = 5;
    localparam int c_FMAX    = 6;
    localparam int c_FMVXW   = 7;
    localparam int c_FMVWX   = 8;
    localparam int c_FEQ     = 9;
    localparam int c_FLT     = 10;
    localparam int c_FLE     = 11;
    localparam int c_FMADD   = 12;
    localparam int c_FMSUB   = 13;
    localparam int c_FCVTWS  = 14;
    localparam int c_FCVTSW  = 15;
    localparam int c_FNMSUB  = 16;
    localparam int c_FNMADD  = 17;
    localparam int c_FSGNJ   = 18;
    localparam int c_FSGNJN  = 19;
    localparam int c_FSGNJX  = 20;
    localparam int c_FCLASS  = 21;
    localparam int c_UNSIGND = 22;
    localparam int c_SIGNED  = 23;

    // Major opcodes.
    localparam logic [6:0] c_OPC_OPFP   = 7'b1010011;
    localparam logic [6:0] c_OPC_FMADD  = 7'b1000011;
    localparam logic [6:0] c_OPC_FMSUB  = 7'b1000111;
    localparam logic [6:0] c_OPC_FNMSUB = 7'b1001011;
    localparam logic [6:0] c_OPC_FNMADD = 7'b1001111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [OPW-1:0]  sfpu_op_q, sfpu_op_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic [4:0]      rs3_q, rs3_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      rm_q, rm_d;
    logic            issue_valid_q, issue_valid_d;
    logic            div_q, div_d;
    logic            done_q, done_d;
    logic            illegal_q, illegal_d;

    // Decoder results for the instruction currently on instr_in.
    logic [23:0]     w_dec_op;
    logic            w_dec_legal;
    logic            w_dec_div;
    logic            w_dec_r4;

    logic [6:0]      w_opcode;
    logic [4:0]      w_funct5;
    logic [1:0]      w_fmt;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rs2f;

    assign w_opcode = instr_in[6:0];
    assign w_funct5 = instr_in[31:27];
    assign w_fmt    = instr_in[26:25];
    assign w_funct3 = instr_in[14:12];
    assign w_rs2f   = instr_in[24:20];

    // Combinational RV32F decode to one-hot opcode vector; any combination
    // that sets no op bit is treated as illegal.
    always_comb begin
        w_dec_op  = '0;
        w_dec_div = 1'b0;
        w_dec_r4  = 1'b0;
        if (w_fmt == 2'b00) begin
            case (w_opcode)
                c_OPC_OPFP: begin
                    case (w_funct5)
                        5'b00000: w_dec_op[c_FADD] = 1'b1;
                        5'b00001: w_dec_op[c_FSUB] = 1'b1;
                        5'b00010: w_dec_op[c_FMUL] = 1'b1;
                        5'b00011: begin
                            w_dec_op[c_FDIV] = 1'b1;
                            w_dec_div        = 1'b1;
                        end
                        5'b01011: begin
                            if (w_rs2f == 5'd0) begin
                                w_dec_op[c_FSQRT] = 1'b1;
                                w_dec_div         = 1'b1;
                            end
                        end
                        5'b00100: begin
                            case (w_funct3)
                                3'b000:  w_dec_op[c_FSGNJ]  = 1'b1;
                                3'b001:  w_dec_op[c_FSGNJN] = 1'b1;
                                3'b010:  w_dec_op[c_FSGNJX] = 1'b1;
                                default: ;
                            endcase
                        end
                        5'b00101: begin
                            case (w_funct3)
                                3'b000:  w_dec_op[c_FMIN] = 1'b1;
                                3'b001:  w_dec_op[c_FMAX] = 1'b1;
                                default: ;
                            endcase
                        end
                        5'b10100: begin
                            case (w_funct3)
                                3'b010:  w_dec_op[c_FEQ] = 1'b1;
                                3'b001:  w_dec_op[c_FLT] = 1'b1;
                                3'b000:  w_dec_op[c_FLE] = 1'b1;
                                default: ;
                            endcase
                        end
                        5'b11000: begin
                            // rs2[0] selects unsigned (wu) vs signed (w)
                            if (w_rs2f[4:1] == 4'd0) begin
                                w_dec_op[c_FCVTWS]  = 1'b1;
                                w_dec_op[c_UNSIGND] = w_rs2f[0];
                                w_dec_op[c_SIGNED]  = ~w_rs2f[0];
                            end
                        end
                        5'b11010: begin
                            if (w_rs2f[4:1] == 4'd0) begin
                                w_dec_op[c_FCVTSW]  = 1'b1;
                                w_dec_op[c_UNSIGND] = w_rs2f[0];
                                w_dec_op[c_SIGNED]  = ~w_rs2f[0];
                            end
                        end
                        5'b11100: begin
                            if (w_rs2f == 5'd0) begin
                                case (w_funct3)
                                    3'b000:  w_dec_op[c_FMVXW]  = 1'b1;
                                    3'b001:  w_dec_op[c_FCLASS] = 1'b1;
                                    default: ;
                                endcase
                            end
                        end
                        5'b11110: begin
                            if ((w_rs2f == 5'd0) && (w_funct3 == 3'b000)) begin
                                w_dec_op[c_FMVWX] = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                c_OPC_FMADD: begin
                    w_dec_op[c_FMADD] = 1'b1;
                    w_dec_r4          = 1'b1;
                end
                c_OPC_FMSUB: begin
                    w_dec_op[c_FMSUB] = 1'b1;
                    w_dec_r4          = 1'b1;
                end
                c_OPC_FNMSUB: begin
                    w_dec_op[c_FNMSUB] = 1'b1;
                    w_dec_r4           = 1'b1;
                end
                c_OPC_FNMADD: begin
                    w_dec_op[c_FNMADD] = 1'b1;
                    w_dec_r4           = 1'b1;
                end
                default: ;
            endcase
        end
        w_dec_legal = |w_dec_op[c_FCLASS:c_FADD];
    end

    // Next-state and registered-output logic for the IDLE/ISSUE/BUSY sequencer.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sfpu_op_d     = sfpu_op_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        rs3_d         = rs3_q;
        rd_d          = rd_q;
        rm_d          = rm_q;
        issue_valid_d = issue_valid_q;
        div_d         = div_q;
        done_d        = 1'b0;
        illegal_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The done cycle itself never accepts: the fetch FSM may still
                // be presenting the instruction that just retired.
                if (!done_q && (instr_in != 32'h0)) begin
                    if (w_dec_legal) begin
                        sfpu_op_d     = OPW'(w_dec_op);
                        rs1_d         = instr_in[19:15];
                        rs2_d         = instr_in[24:20];
                        rs3_d         = w_dec_r4 ? instr_in[31:27] : 5'd0;
                        rd_d          = instr_in[11:7];
                        rm_d          = instr_in[14:12];
                        div_d         = w_dec_div;
                        issue_valid_d = 1'b1;
                        state_d       = S_ISSUE;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (issue_valid_q && exec_ready) begin
                    issue_valid_d = 1'b0;
                    if (div_q) begin
                        cnt_d   = CW'(DIV_CYCLES - 1);
                        state_d = S_BUSY;
                    end else begin
                        done_d    = 1'b1;
                        sfpu_op_d = '0;
                        rs1_d     = 5'd0;
                        rs2_d     = 5'd0;
                        rs3_d     = 5'd0;
                        rd_d      = 5'd0;
                        rm_d      = 3'd0;
                        div_d     = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    done_d    = 1'b1;
                    sfpu_op_d = '0;
                    rs1_d     = 5'd0;
                    rs2_d     = 5'd0;
                    rs3_d     = 5'd0;
                    rd_d      = 5'd0;
                    rm_d      = 3'd0;
                    div_d     = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any op in flight without done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            sfpu_op_q     <= '0;
            rs1_q         <= 5'd0;
            rs2_q         <= 5'd0;
            rs3_q         <= 5'd0;
            rd_q          <= 5'd0;
            rm_q          <= 3'd0;
            issue_valid_q <= 1'b0;
            div_q         <= 1'b0;
            done_q        <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sfpu_op_q     <= sfpu_op_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rs3_q         <= rs3_d;
            rd_q          <= rd_d;
            rm_q          <= rm_d;
            issue_valid_q <= issue_valid_d;
            div_q         <= div_d;
            done_q        <= done_d;
            illegal_q     <= illegal_d;
        end
    end

    assign sfpu_op     = sfpu_op_q;
    assign rs1         = rs1_q;
    assign rs2         = rs2_q;
    assign rs3         = rs3_q;
    assign rd          = rd_q;
    assign rm          = rm_q;
    assign issue_valid = issue_valid_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign activation  = (state_q == S_ISSUE) || (state_q == S_BUSY);
    assign multi_cycle = ((state_q == S_ISSUE) && div_q) || (state_q == S_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_fpu_decode_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_decode_issue
// Desc     : Self-checking bench for fpu_decode_issue: directed vector table,
//            reset-in-flight sequence and randomized RV32F encodings checked
//            against an ISA-level expectation built alongside each encoding.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_decode_issue;

    localparam int DIV_CYCLES = 16;
    localparam int OPW        = 24;

    logic            clk;
    logic            rst;
    logic [31:0]     instr_in;
    logic            exec_ready;
    logic [OPW-1:0]  sfpu_op;
    logic [4:0]      rs1, rs2, rs3, rd;
    logic [2:0]      rm;
    logic            issue_valid, multi_cycle, activation, done, illegal;

    int checks   = 0;
    int failures = 0;

    fpu_decode_issue #(
        .DIV_CYCLES (DIV_CYCLES),
        .OPW        (OPW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_in    (instr_in),
        .exec_ready  (exec_ready),
        .sfpu_op     (sfpu_op),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs3         (rs3),
        .rd          (rd),
        .rm          (rm),
        .issue_valid (issue_valid),
        .multi_cycle (multi_cycle),
        .activation  (activation),
        .done        (done),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        bit          legal;
        logic [23:0] op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rs3;
        logic [4:0]  rd;
        logic [2:0]  rm;
        bit          div;
        int          stall;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Build a random instruction of ISA op kind k (sfpu bit index 0..21)
    // together with what the decode stage must report for it.
    task automatic make_vec(input int k, output vec_t v);
        logic [4:0] r1, r2, r3, rdv, f5, r2u;
        logic [2:0] rmv, f3;
        logic [6:0] opc;
        bit         s, isr4;
        r1   = 5'($urandom);
        r2   = 5'($urandom);
        r3   = 5'($urandom);
        rdv  = 5'($urandom);
        rmv  = 3'($urandom);
        s    = 1'($urandom);
        f5   = 5'd0;
        f3   = rmv;
        r2u  = r2;
        opc  = 7'b1010011;
        isr4 = 1'b0;
        v.div = 1'b0;
        v.op  = 24'(1) << k;
        case (k)
            0:  f5 = 5'b00000;
            1:  f5 = 5'b00001;
            2:  f5 = 5'b00010;
            3:  begin f5 = 5'b00011; v.div = 1'b1; end
            4:  begin f5 = 5'b01011; r2u = 5'd0; v.div = 1'b1; end
            5:  begin f5 = 5'b00101; f3 = 3'd0; end
            6:  begin f5 = 5'b00101; f3 = 3'd1; end
            7:  begin f5 = 5'b11100; f3 = 3'd0; r2u = 5'd0; end
            8:  begin f5 = 5'b11110; f3 = 3'd0; r2u = 5'd0; end
            9:  begin f5 = 5'b10100; f3 = 3'd2; end
            10: begin f5 = 5'b10100; f3 = 3'd1; end
            11: begin f5 = 5'b10100; f3 = 3'd0; end
            12: begin isr4 = 1'b1; opc = 7'b1000011; end
            13: begin isr4 = 1'b1; opc = 7'b1000111; end
            14: begin f5 = 5'b11000; r2u = {4'd0, s}; v.op[s ? 22 : 23] = 1'b1; end
            15: begin f5 = 5'b11010; r2u = {4'd0, s}; v.op[s ? 22 : 23] = 1'b1; end
            16: begin isr4 = 1'b1; opc = 7'b1001011; end
            17: begin isr4 = 1'b1; opc = 7'b1001111; end
            18: begin f5 = 5'b00100; f3 = 3'd0; end
            19: begin f5 = 5'b00100; f3 = 3'd1; end
            20: begin f5 = 5'b00100; f3 = 3'd2; end
            default: begin f5 = 5'b11100; f3 = 3'd1; r2u = 5'd0; end
        endcase
        if (isr4) v.instr = {r3, 2'b00, r2u, r1, f3, rdv, opc};
        else      v.instr = {f5, 2'b00, r2u, r1, f3, rdv, opc};
        v.legal = 1'b1;
        v.rs1   = r1;
        v.rs2   = r2u;
        v.rs3   = isr4 ? r3 : 5'd0;
        v.rd    = rdv;
        v.rm    = f3;
        v.stall = $urandom_range(0, 3);
        // A non-single-precision fmt field makes any of these illegal.
        if ($urandom_range(0, 6) == 0) begin
            v.instr[26:25] = 2'($urandom_range(1, 3));
            v.legal = 1'b0;
        end
    endtask

    // Present one instruction the way the fetch FSM does (held until the
    // cycle after done) and check the whole issue/retire sequence.
    task automatic run_vec(input vec_t v, input string tag);
        int cnt;
        @(negedge clk);
        instr_in   = v.instr;
        exec_ready = (v.stall == 0);
        @(negedge clk);
        if (!v.legal) begin
            chk({tag, " illegal_pulse"}, 32'(illegal), 1);
            chk({tag, " illegal_valid"}, 32'(issue_valid), 0);
            chk({tag, " illegal_op"}, 32'(sfpu_op), 0);
            chk({tag, " illegal_act"}, 32'(activation), 0);
            instr_in = 32'h0;
            @(negedge clk);
            chk({tag, " illegal_one_cycle"}, 32'(illegal), 0);
        end else begin
            chk({tag, " issue_valid"}, 32'(issue_valid), 1);
            chk({tag, " sfpu_op"}, 32'(sfpu_op), 32'(v.op));
            chk({tag, " rs1"}, 32'(rs1), 32'(v.rs1));
            chk({tag, " rs2"}, 32'(rs2), 32'(v.rs2));
            chk({tag, " rs3"}, 32'(rs3), 32'(v.rs3));
            chk({tag, " rd"}, 32'(rd), 32'(v.rd));
            chk({tag, " rm"}, 32'(rm), 32'(v.rm));
            chk({tag, " activation"}, 32'(activation), 1);
            chk({tag, " multi_cycle"}, 32'(multi_cycle), 32'(v.div));
            chk({tag, " no_illegal"}, 32'(illegal), 0);
            for (int i = 0; i < v.stall; i++) begin
                @(negedge clk);
                chk({tag, " stall_valid"}, 32'(issue_valid), 1);
                chk({tag, " stall_op"}, 32'(sfpu_op), 32'(v.op));
                chk({tag, " stall_rd"}, 32'(rd), 32'(v.rd));
                chk({tag, " stall_multi"}, 32'(multi_cycle), 32'(v.div));
            end
            exec_ready = 1'b1;
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
                if (v.div && cnt == 2) begin
                    chk({tag, " busy_multi"}, 32'(multi_cycle), 1);
                    chk({tag, " busy_valid"}, 32'(issue_valid), 0);
                    chk({tag, " busy_act"}, 32'(activation), 1);
                end
            end while (!done && cnt < DIV_CYCLES + 8);
            // Handshake edge is cnt==1; fdiv/fsqrt retire DIV_CYCLES edges later.
            chk({tag, " done_latency"}, 32'(cnt), v.div ? 32'(DIV_CYCLES + 1) : 32'd1);
            chk({tag, " done_op_clear"}, 32'(sfpu_op), 0);
            chk({tag, " done_valid"}, 32'(issue_valid), 0);
            chk({tag, " done_act"}, 32'(activation), 0);
            @(negedge clk);
            chk({tag, " done_pulse"}, 32'(done), 0);
            chk({tag, " no_reaccept"}, 32'(activation), 0);
            instr_in   = 32'h0;
            exec_ready = 1'($urandom);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   seen_done;
        vec_t v;

        tbl[0] = '{32'h002081D3, 1'b1, 24'h000001, 5'd1, 5'd2, 5'd0, 5'd3, 3'd0, 1'b0, 0};
        tbl[1] = '{32'h182081D3, 1'b1, 24'h000008, 5'd1, 5'd2, 5'd0, 5'd3, 3'd0, 1'b1, 3};
        tbl[2] = '{32'h18208243, 1'b1, 24'h001000, 5'd1, 5'd2, 5'd3, 5'd4, 3'd0, 1'b0, 0};
        tbl[3] = '{32'h580081D3, 1'b1, 24'h000010, 5'd1, 5'd0, 5'd0, 5'd3, 3'd0, 1'b1, 0};
        tbl[4] = '{32'hC01082D3, 1'b1, 24'h404000, 5'd1, 5'd1, 5'd0, 5'd5, 3'd0, 1'b0, 1};
        tbl[5] = '{32'hC00082D3, 1'b1, 24'h804000, 5'd1, 5'd0, 5'd0, 5'd5, 3'd0, 1'b0, 0};
        tbl[6] = '{32'h282081D3, 1'b1, 24'h000020, 5'd1, 5'd2, 5'd0, 5'd3, 3'd0, 1'b0, 2};
        tbl[7] = '{32'hA020A1D3, 1'b1, 24'h000200, 5'd1, 5'd2, 5'd0, 5'd3, 3'd2, 1'b0, 0};
        tbl[8] = '{32'hFFFFFFFF, 1'b0, 24'h000000, 5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 0};
        tbl[9] = '{32'h022081D3, 1'b0, 24'h000000, 5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 0};

        rst        = 1'b1;
        instr_in   = 32'h0;
        exec_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset sfpu_op", 32'(sfpu_op), 0);
        chk("reset issue_valid", 32'(issue_valid), 0);
        chk("reset activation", 32'(activation), 0);
        chk("reset multi_cycle", 32'(multi_cycle), 0);
        chk("reset done", 32'(done), 0);
        chk("reset illegal", 32'(illegal), 0);
        chk("reset rd", 32'(rd), 0);
        rst = 1'b0;

        // Bubbles: nothing may change.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exec_ready = 1'($urandom);
            chk("bubble sfpu_op", 32'(sfpu_op), 0);
            chk("bubble valid", 32'(issue_valid), 0);
            chk("bubble act", 32'(activation), 0);
            chk("bubble done", 32'(done), 0);
            chk("bubble illegal", 32'(illegal), 0);
        end

        for (int i = 0; i < 10; i++) begin
            run_vec(tbl[i], $sformatf("tbl%0d", i));
        end

        // Reset five cycles into an fdiv BUSY phase.
        @(negedge clk);
        instr_in   = 32'h182081D3;
        exec_ready = 1'b1;
        @(negedge clk);
        chk("rstseq issue", 32'(issue_valid), 1);
        @(negedge clk);
        chk("rstseq busy", 32'(multi_cycle), 1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstseq op", 32'(sfpu_op), 0);
        chk("rstseq act", 32'(activation), 0);
        chk("rstseq multi", 32'(multi_cycle), 0);
        chk("rstseq valid", 32'(issue_valid), 0);
        chk("rstseq rd", 32'(rd), 0);
        instr_in = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || activation) seen_done = 1'b1;
        end
        chk("rstseq no_done", 32'(seen_done), 0);
        run_vec(tbl[0], "post_rst fadd");

        // Randomized ops across every decode class.
        for (int n = 0; n < 150; n++) begin
            make_vec($urandom_range(0, 21), v);
            run_vec(v, $sformatf("rnd%0d %08h", n, v.instr));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
